// File: rtl/cla_seq_arbiter.sv
// Two-requester round-robin sequencer around one 4-bit carry-lookahead slice,
// adding WIDTH-bit operands a nibble per cycle. Define CLA_SEQ_OVF_EN to add res_ovf.
module cla_seq_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    input  logic             res_ready,
`ifdef CLA_SEQ_OVF_EN
    output logic             res_ovf,
`endif
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [NW-1:0] LAST_NIB = NW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 4-bit CLA slice: returns {carry out, carry into bit 3, sum}
    function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[4], c[3], p ^ c[3:0]};
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic             last_grant_r;
    logic             grant_s;
    logic             accept_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [NW-1:0]    nib_r;
    logic [5:0]       slice_s;

    assign slice_s = cla4(a_r[nib_r*4 +: 4], b_r[nib_r*4 +: 4], carry_r);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Arbitration, combinational ready and next-state decode
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_s = ~last_grant_r;
                end else if (req1_valid) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
                req0_ready = ~grant_s & req0_valid;
                req1_ready = grant_s & req1_valid;
                accept_s   = req0_ready | req1_ready;
                if (accept_s) begin
                    next_state_s = S_ADD;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ADD: begin
                if (nib_r == LAST_NIB) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_ADD;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Operand capture, nibble-serial accumulation and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            a_r          <= '0;
            b_r          <= '0;
            carry_r      <= 1'b0;
            nib_r        <= '0;
            res_sum      <= '0;
            res_cout     <= 1'b0;
            res_id       <= 1'b0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            res_ovf      <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        a_r          <= grant_s ? req1_a : req0_a;
                        b_r          <= grant_s ? req1_b : req0_b;
                        res_id       <= grant_s;
                        last_grant_r <= grant_s;
                        carry_r      <= 1'b0;
                        nib_r        <= '0;
                    end
                end
                S_ADD: begin
                    res_sum[nib_r*4 +: 4] <= slice_s[3:0];
                    carry_r               <= slice_s[5];
                    nib_r                 <= nib_r + NW'(1);
                    if (nib_r == LAST_NIB) begin
                        res_cout <= slice_s[5];
`ifdef CLA_SEQ_OVF_EN
                        res_ovf  <= slice_s[5] ^ slice_s[4];
`endif
                    end
                end
                default: begin
                end
            endcase
            // Status flags track the state being entered so they line up with it
            busy      <= (next_state_s != S_IDLE);
            res_valid <= (next_state_s == S_DONE);
        end
    end

endmodule
